adder_accumulator: RTL and testbench

Sequential stage directly downstream of the 4-bit ripple adder. It samples the adder's 5-bit result ({carry, sum}) on each externally strobed pin event and accumulates a batch of BATCH results into a wider register. It flags batch completion and sticky overflow. The strobe and clear pins are asynchronous to clk, so the block synchronises them and detects edges itself.

---
 rtl/adder_acc_pkg.sv | 14 +
 rtl/pin_sync.sv | 37 +++
 rtl/adder_accumulator.sv | 104 ++++++++++
 tb/tb_adder_accumulator.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_acc_pkg.sv
// rtl/adder_acc_pkg.sv - shared types and defaults for the adder accumulator
package adder_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SAMPLE_W      = 5;
  localparam int DEFAULT_BATCH = 4;
  localparam int DEFAULT_ACC_W = 8;

endpackage

// File: rtl/pin_sync.sv
// rtl/pin_sync.sv - two-flop pin synchroniser with optional rising-edge pulse
module pin_sync #(
  parameter bit RISE_EN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic sync
);

  logic s1, s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

  generate
    if (RISE_EN) begin : g_rise
      logic s3;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s3 <= 1'b0;
        else        s3 <= s2;
      end
      // One-cycle pulse per synchronised rising edge; a held-high pin fires once.
      assign sync = s2 & ~s3;
    end else begin : g_level
      assign sync = s2;
    end
  endgenerate

endmodule

// File: rtl/adder_accumulator.sv
// rtl/adder_accumulator.sv - batches strobed 5-bit adder results into a wide accumulator
module adder_accumulator
  import adder_acc_pkg::*;
#(
  parameter int ACC_W = DEFAULT_ACC_W,
  parameter int BATCH = DEFAULT_BATCH,
  parameter int CNT_W = $clog2(BATCH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [3:0]       sum_in,
  input  logic             cout_in,
  input  logic             strobe_in,
  input  logic             clear_in,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] count_out,
  output logic             done_out,
  output logic             busy_out,
  output logic             ovf_out
);

  localparam logic [CNT_W-1:0] BATCH_CNT = CNT_W'(BATCH);

  state_t           state, next_state;
  logic             pulse, clr, accept;
  logic [ACC_W:0]   sample_ext, sum_full;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] count_next, count_inc;
  logic             ovf_next;

  pin_sync #(.RISE_EN(1'b1)) u_strobe_sync (
    .clk(clk), .rst_n(rst_n), .pin(strobe_in), .sync(pulse)
  );

  pin_sync #(.RISE_EN(1'b0)) u_clear_sync (
    .clk(clk), .rst_n(rst_n), .pin(clear_in), .sync(clr)
  );

  assign accept     = pulse & ena;
  assign sample_ext = {{(ACC_W + 1 - SAMPLE_W){1'b0}}, cout_in, sum_in};
  assign sum_full   = {1'b0, acc_out} + sample_ext;
  assign count_inc  = count_out + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Clear dominates any pulse arriving in the same cycle.
  always_comb begin
    next_state = state;
    if (clr) begin
      next_state = IDLE;
    end else if (accept) begin
      case (state)
        IDLE:    next_state = (BATCH == 1) ? DONE : ACCUM;
        ACCUM:   if (count_inc == BATCH_CNT) next_state = DONE;
        default: next_state = state;
      endcase
    end
  end

  always_comb begin
    acc_next   = acc_out;
    count_next = count_out;
    ovf_next   = ovf_out;
    if (clr) begin
      acc_next   = '0;
      count_next = '0;
      ovf_next   = 1'b0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          acc_next   = sample_ext[ACC_W-1:0];
          count_next = CNT_W'(1);
        end
        ACCUM: begin
          acc_next   = sum_full[ACC_W-1:0];
          count_next = count_inc;
          ovf_next   = ovf_out | sum_full[ACC_W];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out   <= '0;
      count_out <= '0;
      ovf_out   <= 1'b0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      acc_out   <= acc_next;
      count_out <= count_next;
      ovf_out   <= ovf_next;
      busy_out  <= (next_state == ACCUM);
      done_out  <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_adder_accumulator.sv
// tb/tb_adder_accumulator.sv - randomized and directed checks of adder_accumulator against a behavioural model
module tb_adder_accumulator;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n, ena, cout_in, strobe_in, clear_in;
  logic [3:0] sum_in;
  logic [7:0] acc4, acc16;
  logic [2:0] cnt4;
  logic [4:0] cnt16;
  logic done4, busy4, ovf4, done16, busy16, ovf16;
  logic chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 if (clk_en) clk = ~clk;

  adder_accumulator #(.ACC_W(8), .BATCH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sum_in(sum_in), .cout_in(cout_in),
    .strobe_in(strobe_in), .clear_in(clear_in), .acc_out(acc4), .count_out(cnt4),
    .done_out(done4), .busy_out(busy4), .ovf_out(ovf4)
  );

  adder_accumulator #(.ACC_W(8), .BATCH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sum_in(sum_in), .cout_in(cout_in),
    .strobe_in(strobe_in), .clear_in(clear_in), .acc_out(acc16), .count_out(cnt16),
    .done_out(done16), .busy_out(busy16), .ovf_out(ovf16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pin samples taken at each edge; a sample request is a 0->1 pin
  // change seen two edges earlier, clear is the pin level two edges earlier.
  int  m_acc[2], m_cnt[2];
  bit  m_ovf[2];
  int  bsz[2] = '{4, 16};
  bit  st_hist[3], cl_hist[3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
      end
      for (int k = 0; k < 3; k++) begin
        st_hist[k] = 0; cl_hist[k] = 0;
      end
    end else begin
      bit ev, clr;
      int v;
      ev  = st_hist[1] && !st_hist[2];
      clr = cl_hist[1];
      v   = {cout_in, sum_in};
      for (int k = 0; k < 2; k++) begin
        if (clr) begin
          m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
        end else if (ev && ena && m_cnt[k] < bsz[k]) begin
          if (m_acc[k] + v > 255) m_ovf[k] = 1;
          m_acc[k] = (m_acc[k] + v) % 256;
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
      st_hist[2] = st_hist[1]; st_hist[1] = st_hist[0]; st_hist[0] = strobe_in;
      cl_hist[2] = cl_hist[1]; cl_hist[1] = cl_hist[0]; cl_hist[0] = clear_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("acc4",   32'(acc4),   32'(m_acc[0]));
      check("cnt4",   32'(cnt4),   32'(m_cnt[0]));
      check("done4",  32'(done4),  32'(m_cnt[0] == 4));
      check("busy4",  32'(busy4),  32'(m_cnt[0] > 0 && m_cnt[0] < 4));
      check("ovf4",   32'(ovf4),   32'(m_ovf[0]));
      check("acc16",  32'(acc16),  32'(m_acc[1]));
      check("cnt16",  32'(cnt16),  32'(m_cnt[1]));
      check("done16", 32'(done16), 32'(m_cnt[1] == 16));
      check("busy16", 32'(busy16), 32'(m_cnt[1] > 0 && m_cnt[1] < 16));
      check("ovf16",  32'(ovf16),  32'(m_ovf[1]));
    end
  end

  task automatic strobe(input int value, input int hi, input int lo);
    @(negedge clk);
    {cout_in, sum_in} = 5'(value);
    strobe_in = 1'b1;
    repeat (hi) @(negedge clk);
    strobe_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_in = 1'b1;
    repeat (4) @(negedge clk);
    check("clear_acc4", 32'(acc4), 32'd0);
    clear_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_acc"},  32'({acc4, acc16}), 32'd0);
    check({tag, "_cnt"},  32'({cnt4, cnt16}), 32'd0);
    check({tag, "_flag"}, 32'({done4, busy4, ovf4, done16, busy16, ovf16}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b1; sum_in = '0; cout_in = 1'b0;
    strobe_in = 1'b0; clear_in = 1'b0;

    // Reset with no clock running
    #5 rst_n = 1'b0;
    #1 all_zero("rst_noclk");
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);
    all_zero("idle5");

    // Batch of four 15s, then an ignored fifth
    for (int i = 1; i <= 4; i++) begin
      strobe(15, 3, 3);
      check("batch_acc", 32'(acc4), 32'(15 * i));
    end
    check("batch_done", 32'({cnt4, done4, ovf4}), {27'd0, 3'd4, 1'b1, 1'b0});
    strobe(15, 3, 3);
    check("batch_fifth", 32'({acc4, cnt4}), {21'd0, 8'h3C, 3'd4});

    // Overflow on the 16-sample instance
    do_clear();
    repeat (9) strobe(31, 3, 3);
    check("ovf_acc", 32'(acc16), 32'h17);
    check("ovf_flag", 32'(ovf16), 32'd1);
    repeat (7) strobe(0, 3, 3);
    check("ovf_sticky", 32'({ovf16, done16}), 32'b11);

    // Held-high strobe counts once
    do_clear();
    strobe(7, 10, 3);
    check("held_acc", 32'({acc4, cnt4}), {21'd0, 8'd7, 3'd1});

    // Pin rise to result is exactly three edges
    do_clear();
    @(negedge clk);
    {cout_in, sum_in} = 5'd9;
    strobe_in = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 check("lat_e2", 32'(acc4), 32'd0);
    @(posedge clk);
    #1 check("lat_e3", 32'(acc4), 32'd9);
    @(negedge clk) strobe_in = 1'b0;
    repeat (3) @(negedge clk);

    // Clear and event rising together
    do_clear();
    strobe(20, 3, 3);
    check("sim_pre", 32'({acc4, busy4}), {23'd0, 8'd20, 1'b1});
    @(negedge clk);
    {cout_in, sum_in} = 5'd5;
    clear_in = 1'b1;
    strobe_in = 1'b1;
    repeat (4) @(negedge clk);
    check("sim_clr", 32'({acc4, cnt4, busy4}), 32'd0);
    clear_in = 1'b0;
    repeat (3) @(negedge clk);
    strobe_in = 1'b0;
    repeat (3) @(negedge clk);
    check("sim_drop", 32'({acc4, cnt4}), 32'd0);

    // Gated strobe, then async reset mid-batch
    strobe(3, 3, 3);
    ena = 1'b0;
    strobe(11, 3, 3);
    ena = 1'b1;
    check("ena_gate", 32'({acc4, cnt4}), {21'd0, 8'd3, 3'd1});
    strobe(4, 3, 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 all_zero("rst_async");
    @(negedge clk) rst_n = 1'b1;
    strobe(6, 3, 3);
    check("post_rst", 32'({acc4, cnt4}), {21'd0, 8'd6, 3'd1});

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(9) == 0) do_clear();
      else begin
        ena = ($urandom_range(3) != 0);
        strobe($urandom_range(31), $urandom_range(1, 4), $urandom_range(2, 4));
      end
    end
    ena = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
